// File: rtl/taxi_eth_mac_tx_sched.sv
// Frame-granular round-robin scheduler sharing one MAC TX stream and its
// completion stream between PORTS requesters. Each frame is tagged with
// {per-port sequence, port index}. Completions are routed back by the port
// index held in the low tag bits. Each port is limited to MAX_OUTSTANDING
// frames in flight.
module taxi_eth_mac_tx_sched #(
    parameter int PORTS           = 4,
    parameter int DATA_W          = 64,
    parameter int KEEP_W          = DATA_W / 8,
    parameter int TAG_W           = 16,
    parameter int CPL_W           = 96,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [PORTS*DATA_W-1:0]  s_axis_tdata,
    input  logic [PORTS*KEEP_W-1:0]  s_axis_tkeep,
    input  logic [PORTS-1:0]         s_axis_tvalid,
    output logic [PORTS-1:0]         s_axis_tready,
    input  logic [PORTS-1:0]         s_axis_tlast,
    input  logic [PORTS-1:0]         s_axis_tuser,

    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [KEEP_W-1:0]        m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic [TAG_W-1:0]         m_axis_tid,

    input  logic [CPL_W-1:0]         s_axis_cpl_tdata,
    input  logic [TAG_W-1:0]         s_axis_cpl_tid,
    input  logic                     s_axis_cpl_tvalid,
    output logic                     s_axis_cpl_tready,

    output logic [CPL_W-1:0]         m_axis_cpl_tdata,
    output logic [TAG_W-1:0]         m_axis_cpl_tid,
    output logic [PORTS-1:0]         m_axis_cpl_tvalid,
    input  logic [PORTS-1:0]         m_axis_cpl_tready,

    input  logic [PORTS-1:0]         cfg_port_en,
    output logic [PORTS-1:0]         stat_outstanding_full,
    output logic                     stat_cpl_err
);

    localparam int SEL_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int SEQ_W = TAG_W - SEL_W;
    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [SEL_W:0]   PORTS_W   = (SEL_W + 1)'(PORTS);
    localparam logic [SEL_W-1:0] LAST_PORT = SEL_W'(PORTS - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_rr;
    logic [TAG_W-1:0] r_tid;
    logic [SEQ_W-1:0] r_seq         [PORTS];
    logic [CNT_W-1:0] r_outstanding [PORTS];
    logic [PORTS-1:0] r_full;
    logic             r_cpl_err;

    logic [PORTS-1:0] w_eligible;
    logic [PORTS-1:0] w_inc;
    logic [PORTS-1:0] w_dec;
    logic             w_grant_valid;
    logic [SEL_W-1:0] w_grant_sel;
    logic [SEL_W:0]   w_scan_idx;
    logic             w_tx_done;
    logic [SEL_W-1:0] w_cpl_idx;
    logic             w_cpl_idx_ok;
    logic             w_cpl_hs;
    logic             w_cpl_underflow;

    // A port may be granted only when it has data, is enabled and has room in flight.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            w_eligible[i] = s_axis_tvalid[i] & cfg_port_en[i] & (r_outstanding[i] < MAX_CNT);
        end
    end

    // Pick the first eligible port at or after the round-robin pointer; the scan
    // runs from the far end so the closest eligible port is written last and wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch, otherwise a path that skips the assignment infers a latch.
        w_grant_valid = 1'b0;
        w_grant_sel   = '0;
        w_scan_idx    = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            w_scan_idx = {1'b0, r_rr} + (SEL_W + 1)'(k);
            if (w_scan_idx >= PORTS_W) begin
                w_scan_idx = w_scan_idx - PORTS_W;
            end
            if (w_eligible[w_scan_idx[SEL_W-1:0]]) begin
                w_grant_valid = 1'b1;
                w_grant_sel   = w_scan_idx[SEL_W-1:0];
            end
        end
    end

    // FSM state register; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and the combinational pass-through from the granted port.
    always_comb begin
        w_state_next  = r_state;
        m_axis_tdata  = s_axis_tdata[r_sel*DATA_W +: DATA_W];
        m_axis_tkeep  = s_axis_tkeep[r_sel*KEEP_W +: KEEP_W];
        m_axis_tlast  = s_axis_tlast[r_sel];
        m_axis_tuser  = s_axis_tuser[r_sel];
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        w_tx_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                m_axis_tvalid        = s_axis_tvalid[r_sel];
                s_axis_tready[r_sel] = m_axis_tready;
                w_tx_done            = s_axis_tvalid[r_sel] & m_axis_tready & s_axis_tlast[r_sel];
                if (w_tx_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign m_axis_tid = r_tid;

    // Latch the grant and its tag in IDLE; advance the pointer past the port at end of frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= '0;
            r_rr  <= '0;
            r_tid <= '0;
        end else if (r_state == ST_IDLE && w_grant_valid) begin
            r_sel <= w_grant_sel;
            r_tid <= {r_seq[w_grant_sel], w_grant_sel};
        end else if (w_tx_done) begin
            r_rr <= (r_sel == LAST_PORT) ? '0 : r_sel + 1'b1;
        end
    end

    // Completion routing by the port index in the low tag bits; unknown ports are dropped.
    always_comb begin
        w_cpl_idx         = s_axis_cpl_tid[SEL_W-1:0];
        w_cpl_idx_ok      = ({1'b0, w_cpl_idx} < PORTS_W);
        m_axis_cpl_tdata  = s_axis_cpl_tdata;
        m_axis_cpl_tid    = s_axis_cpl_tid;
        m_axis_cpl_tvalid = '0;
        s_axis_cpl_tready = 1'b1;
        if (w_cpl_idx_ok) begin
            m_axis_cpl_tvalid[w_cpl_idx] = s_axis_cpl_tvalid;
            s_axis_cpl_tready            = m_axis_cpl_tready[w_cpl_idx];
        end
        w_cpl_hs        = s_axis_cpl_tvalid & s_axis_cpl_tready;
        w_cpl_underflow = w_cpl_idx_ok & (r_outstanding[w_cpl_idx] == '0) & ~w_inc[w_cpl_idx];
    end

    // Per-port increment at end of a sent frame.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            w_inc[i] = w_tx_done & (r_sel == SEL_W'(i));
        end
    end

    // Per-port decrement on a completion handshake routed to that port.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            w_dec[i] = w_cpl_hs & w_cpl_idx_ok & (w_cpl_idx == SEL_W'(i));
        end
    end

    // Sequence and outstanding counters, full flags and the completion error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these per-port arrays are small flop banks whose zero value is
            // architecturally visible (tags, credit), so they are reset like any
            // other register rather than treated as uninitialised storage.
            for (int i = 0; i < PORTS; i++) begin
                r_seq[i]         <= '0;
                r_outstanding[i] <= '0;
            end
            r_full    <= '0;
            r_cpl_err <= 1'b0;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (w_inc[i]) begin
                    r_seq[i] <= r_seq[i] + 1'b1;
                end
                if (w_inc[i] && !w_dec[i]) begin
                    r_outstanding[i] <= r_outstanding[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i] && r_outstanding[i] != '0) begin
                    r_outstanding[i] <= r_outstanding[i] - 1'b1;
                end
                r_full[i] <= (r_outstanding[i] == MAX_CNT);
            end
            r_cpl_err <= w_cpl_hs & (~w_cpl_idx_ok | w_cpl_underflow);
        end
    end

    assign stat_outstanding_full = r_full;
    assign stat_cpl_err          = r_cpl_err;

endmodule

// File: tb/tb_taxi_eth_mac_tx_sched.sv
// Directed bench for the TX scheduler. dut_a uses the default build (4 ports,
// 8 in flight); dut_b is a 3-port build limited to 2 frames in flight so that
// the credit limit and out-of-range completion tags can be exercised. Both
// share the stimulus; use_b selects whose handshakes drive the source model.
module tb_taxi_eth_mac_tx_sched;

    localparam int P  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int TW = 16;
    localparam int CW = 96;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [P*DW-1:0] s_tdata;
    logic [P*KW-1:0] s_tkeep;
    logic [P-1:0]    s_tvalid, s_tlast, s_tuser, cfg_en, mc_tready;
    logic            m_tready;
    logic [CW-1:0]   c_tdata;
    logic [TW-1:0]   c_tid;
    logic            c_tvalid;

    logic [P-1:0]  a_s_tready, a_mc_tvalid, a_full;
    logic [DW-1:0] a_m_tdata;
    logic [KW-1:0] a_m_tkeep;
    logic          a_m_tvalid, a_m_tlast, a_m_tuser, a_c_tready, a_err;
    logic [TW-1:0] a_m_tid, a_mc_tid;
    logic [CW-1:0] a_mc_tdata;

    logic [2:0]    b_s_tready, b_mc_tvalid, b_full;
    logic [DW-1:0] b_m_tdata;
    logic [KW-1:0] b_m_tkeep;
    logic          b_m_tvalid, b_m_tlast, b_m_tuser, b_c_tready, b_err;
    logic [TW-1:0] b_m_tid, b_mc_tid;
    logic [CW-1:0] b_mc_tdata;

    taxi_eth_mac_tx_sched dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(a_s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tvalid(a_m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(a_m_tlast), .m_axis_tuser(a_m_tuser),
        .m_axis_tid(a_m_tid),
        .s_axis_cpl_tdata(c_tdata), .s_axis_cpl_tid(c_tid), .s_axis_cpl_tvalid(c_tvalid),
        .s_axis_cpl_tready(a_c_tready),
        .m_axis_cpl_tdata(a_mc_tdata), .m_axis_cpl_tid(a_mc_tid),
        .m_axis_cpl_tvalid(a_mc_tvalid), .m_axis_cpl_tready(mc_tready),
        .cfg_port_en(cfg_en), .stat_outstanding_full(a_full), .stat_cpl_err(a_err)
    );

    taxi_eth_mac_tx_sched #(.PORTS(3), .MAX_OUTSTANDING(2)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[3*DW-1:0]), .s_axis_tkeep(s_tkeep[3*KW-1:0]),
        .s_axis_tvalid(s_tvalid[2:0]), .s_axis_tready(b_s_tready),
        .s_axis_tlast(s_tlast[2:0]), .s_axis_tuser(s_tuser[2:0]),
        .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser),
        .m_axis_tid(b_m_tid),
        .s_axis_cpl_tdata(c_tdata), .s_axis_cpl_tid(c_tid), .s_axis_cpl_tvalid(c_tvalid),
        .s_axis_cpl_tready(b_c_tready),
        .m_axis_cpl_tdata(b_mc_tdata), .m_axis_cpl_tid(b_mc_tid),
        .m_axis_cpl_tvalid(b_mc_tvalid), .m_axis_cpl_tready(mc_tready[2:0]),
        .cfg_port_en(cfg_en[2:0]), .stat_outstanding_full(b_full), .stat_cpl_err(b_err)
    );

    // View of whichever DUT is under test.
    logic          use_b = 1'b0;
    logic [P-1:0]  v_s_tready;
    logic [DW-1:0] v_m_tdata;
    logic          v_m_tvalid, v_m_tlast;
    logic [TW-1:0] v_m_tid;
    assign v_s_tready = use_b ? {1'b0, b_s_tready} : a_s_tready;
    assign v_m_tdata  = use_b ? b_m_tdata  : a_m_tdata;
    assign v_m_tvalid = use_b ? b_m_tvalid : a_m_tvalid;
    assign v_m_tlast  = use_b ? b_m_tlast  : a_m_tlast;
    assign v_m_tid    = use_b ? b_m_tid    : a_m_tid;

    // Source model state: beat payload = {frame, port, beat} in the low 24 bits.
    int frames_left [P];
    int beat_no     [P];
    int frame_no    [P];
    int frame_len   [P];

    typedef struct {
        int          port;
        int          frame;
        int          beat;
        logic [TW-1:0] tid;
        logic        last;
        int          cyc;
    } beat_t;

    beat_t log_q [$];
    int    cyc   = 0;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int p = 0; p < P; p++) begin
            s_tvalid[p]           = frames_left[p] > 0;
            s_tdata[p*DW +: DW]   = {40'd0, 8'(frame_no[p]), 8'(p), 8'(beat_no[p])};
            s_tkeep[p*KW +: KW]   = '1;
            s_tlast[p]            = (beat_no[p] == frame_len[p] - 1);
            s_tuser[p]            = 1'b0;
        end
    endtask

    // One clock: sample handshakes at the falling edge, update sources after the rising edge.
    task automatic tick();
        logic [P-1:0] hs;
        beat_t        b;
        @(negedge clk);
        hs = s_tvalid & v_s_tready;
        if (v_m_tvalid && m_tready) begin
            b.port  = int'(v_m_tdata[15:8]);
            b.frame = int'(v_m_tdata[23:16]);
            b.beat  = int'(v_m_tdata[7:0]);
            b.tid   = v_m_tid;
            b.last  = v_m_tlast;
            b.cyc   = cyc;
            log_q.push_back(b);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < P; p++) begin
            if (hs[p]) begin
                beat_no[p]++;
                if (beat_no[p] == frame_len[p]) begin
                    beat_no[p] = 0;
                    frames_left[p]--;
                    frame_no[p]++;
                end
            end
        end
        drive_src();
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && log_q.size() < n; i++) tick();
        check(tag, log_q.size() >= n, 1'b1);
    endtask

    function automatic beat_t frame_start(input int n);
        beat_t r;
        int    k;
        r = '{port: -1, frame: -1, beat: -1, tid: '0, last: 1'b0, cyc: -1};
        k = 0;
        foreach (log_q[i]) begin
            if (log_q[i].beat == 0) begin
                if (k == n) return log_q[i];
                k++;
            end
        end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < P; p++) begin
            frames_left[p] = 0;
            beat_no[p]     = 0;
            frame_no[p]    = 0;
            frame_len[p]   = 1;
        end
        drive_src();
        c_tvalid  = 1'b0;
        c_tid     = '0;
        c_tdata   = '0;
        mc_tready = '1;
        m_tready  = 1'b1;
        cfg_en    = '1;
        log_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t s;
        int    c0;
        int    h;
        logic [TW-1:0] exp_tid [5];
        int            exp_port[5];

        // ---------------- reset state (dut_a) ----------------
        use_b = 1'b0;
        do_reset();
        check("rst_m_tvalid", a_m_tvalid, 1'b0);
        check("rst_s_tready", a_s_tready, 4'b0000);
        check("rst_cpl_tvalid", a_mc_tvalid, 4'b0000);
        check("rst_cpl_err", a_err, 1'b0);
        check("rst_full", a_full, 4'b0000);
        check("rst_outstanding0", dut_a.r_outstanding[0], 0);

        // ---------------- one 3-beat frame per port ----------------
        for (int p = 0; p < P; p++) begin
            frame_len[p]   = 3;
            frames_left[p] = 1;
        end
        drive_src();
        c0 = cyc;
        wait_log(12, 40, "rr4_beats");
        for (int f = 0; f < 4; f++) begin
            s = frame_start(f);
            check($sformatf("rr4_port_f%0d", f), s.port, f);
            check($sformatf("rr4_tid_f%0d", f), s.tid, 16'(f));
            check($sformatf("rr4_cyc_f%0d", f), s.cyc, c0 + 1 + 4 * f);
        end
        check("rr4_last_mid", log_q[1].last, 1'b0);
        check("rr4_last_end", log_q[2].last, 1'b1);

        // ---------------- completion held by per-port tready ----------------
        c_tdata   = 96'h0123_4567_89ab_cdef_f00d_cafe;
        c_tid     = 16'h0003;
        c_tvalid  = 1'b1;
        mc_tready = 4'b0111;
        #1;
        check("hold_cpl_tvalid", a_mc_tvalid, 4'b1000);
        check("hold_cpl_tready", a_c_tready, 1'b0);
        check("hold_cpl_data", a_mc_tdata, 96'h0123_4567_89ab_cdef_f00d_cafe);
        tick();
        check("hold_outstanding3", dut_a.r_outstanding[3], 1);
        mc_tready = 4'b1111;
        #1;
        check("release_cpl_tready", a_c_tready, 1'b1);
        tick();
        c_tvalid = 1'b0;
        check("release_outstanding3", dut_a.r_outstanding[3], 0);
        check("release_no_err", a_err, 1'b0);

        // ---------------- port 1 back-to-back against port 2 ----------------
        do_reset();
        frame_len[1] = 2; frames_left[1] = 3;
        frame_len[2] = 2; frames_left[2] = 4;
        drive_src();
        c0 = cyc;
        exp_port = '{1, 2, 1, 2, 1};
        exp_tid  = '{16'h0001, 16'h0002, 16'h0005, 16'h0006, 16'h0009};
        wait_log(10, 60, "alt_beats");
        for (int f = 0; f < 5; f++) begin
            s = frame_start(f);
            check($sformatf("alt_port_f%0d", f), s.port, exp_port[f]);
            check($sformatf("alt_tid_f%0d", f), s.tid, exp_tid[f]);
        end
        check("alt_cyc_f4", frame_start(4).cyc, c0 + 1 + 12);

        // ---------------- cfg_port_en dropped mid-frame ----------------
        do_reset();
        frame_len[0] = 4; frames_left[0] = 2;
        frame_len[1] = 2; frames_left[1] = 1;
        drive_src();
        wait_log(1, 20, "en_first_beat");
        cfg_en[0] = 1'b0;
        repeat (20) tick();
        check("en_total_beats", log_q.size(), 6);
        check("en_beat3_port", log_q[3].port, 0);
        check("en_beat3_last", log_q[3].last, 1'b1);
        check("en_next_port", log_q[4].port, 1);
        check("en_port0_skipped_tready", a_s_tready[0], 1'b0);
        check("en_idle_tvalid", a_m_tvalid, 1'b0);

        // ---------------- reset asserted mid-frame ----------------
        frame_len[2] = 4; frames_left[2] = 1;
        drive_src();
        wait_log(8, 20, "rstmid_beats");
        check("rstmid_active", a_m_tvalid, 1'b1);
        check("rstmid_tkeep", a_m_tkeep, 8'hFF);
        check("rstmid_tuser", a_m_tuser, 1'b0);
        check("rstmid_pre_outstanding0", dut_a.r_outstanding[0], 1);
        rst = 1'b1;
        #1;
        check("rstmid_tvalid", a_m_tvalid, 1'b0);
        check("rstmid_tready", a_s_tready, 4'b0000);
        check("rstmid_outstanding0", dut_a.r_outstanding[0], 0);
        check("rstmid_outstanding1", dut_a.r_outstanding[1], 0);
        check("rstmid_seq0", dut_a.r_seq[0], 0);
        check("rstmid_tid", a_m_tid, 16'h0000);

        // ---------------- outstanding limit (dut_b: 3 ports, limit 2) ----------------
        use_b = 1'b1;
        do_reset();
        frame_len[0] = 2; frames_left[0] = 3;
        drive_src();
        repeat (20) tick();
        check("lim_beats", log_q.size(), 4);
        check("lim_tid_f1", frame_start(1).tid, 16'h0004);
        check("lim_full0", b_full[0], 1'b1);
        check("lim_stall_tready", b_s_tready[0], 1'b0);
        c_tid    = 16'h0000;
        c_tvalid = 1'b1;
        #1;
        check("lim_cpl_route", b_mc_tvalid, 3'b001);
        check("lim_cpl_tready", b_c_tready, 1'b1);
        h = cyc;
        tick();
        c_tvalid = 1'b0;
        wait_log(6, 20, "lim_third_frame");
        s = frame_start(2);
        check("lim_tid_f2", s.tid, 16'h0008);
        check("lim_cyc_f2", s.cyc, h + 2);

        // ---------------- out-of-range completion tag ----------------
        c_tid     = 16'h0003;
        mc_tready = 4'b0000;
        c_tvalid  = 1'b1;
        #1;
        check("bad_no_fwd", b_mc_tvalid, 3'b000);
        check("bad_tready", b_c_tready, 1'b1);
        tick();
        c_tvalid = 1'b0;
        check("bad_err_pulse", b_err, 1'b1);
        tick();
        check("bad_err_clear", b_err, 1'b0);

        // ---------------- completion to an idle port ----------------
        c_tid     = 16'h0002;
        mc_tready = 4'b0100;
        c_tvalid  = 1'b1;
        #1;
        check("under_fwd", b_mc_tvalid, 3'b100);
        tick();
        c_tvalid = 1'b0;
        check("under_err_pulse", b_err, 1'b1);
        check("under_cnt_zero", dut_b.r_outstanding[2], 0);
        tick();
        check("under_err_clear", b_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
